// File: rtl/dnn_pkg.sv
// Shared types and constants for the dnn_seq control sequencer.
// Holds the FSM state enum, the core weight-memory depth and the fixed
// strobe latencies measured from the bias cycle.
package dnn_pkg;

  localparam int unsigned F_SIZE  = 1024;
  localparam int unsigned RA_W    = $clog2(F_SIZE);

  // Latency of each derived strobe, counted in cycles after `bias`.
  localparam int unsigned UPD_LAT = 2;
  localparam int unsigned NRM_LAT = 3;
  localparam int unsigned OUT_LAT = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXEC,
    BIAS,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/dnn_seq_if.sv
// Control/status bundle between the batch requester and dnn_seq.
// master: requester (drives start/n_in/n_batch, observes the rest).
// slave : sequencer (samples the request, drives strobes, ra, status).
interface dnn_seq_if
  import dnn_pkg::*;
#(
  parameter int unsigned BW = 16
) ();

  logic            start;
  logic [RA_W-1:0] n_in;
  logic [BW-1:0]   n_batch;
  logic            busy;
  logic            done;
  logic            init;
  logic            exec;
  logic            bias;
  logic            update;
  logic [RA_W-1:0] ra;
  logic [BW-1:0]   sample;
  logic            norm_en;
  logic            out_valid;
  logic [BW-1:0]   out_idx;

  modport master (
    output start, n_in, n_batch,
    input  busy, done, init, exec, bias, update, ra, sample,
           norm_en, out_valid, out_idx
  );

  modport slave (
    input  start, n_in, n_batch,
    output busy, done, init, exec, bias, update, ra, sample,
           norm_en, out_valid, out_idx
  );

endinterface

// File: rtl/dnn_delay.sv
// Fixed-depth shift register with synchronous active-high clear.
// Ports: clk, reset, d_i (W bits in), q_o (d_i delayed by DEPTH cycles).
module dnn_delay #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] sr_q;

  // Stage 0 takes the input; higher stages move one step per cycle.
  if (DEPTH > 1) begin : g_multi
    always_ff @(posedge clk) begin
      if (reset) sr_q <= '0;
      else       sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
  end else begin : g_single
    always_ff @(posedge clk) begin
      if (reset) sr_q <= '0;
      else       sr_q <= d_i;
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dnn_seq.sv
// Batch control sequencer for one tiny_dnn_core + normalize pair.
// Per sample: INIT (1) -> EXEC (n_in, ra 0..n_in-1) -> BIAS (1); the bias
// strobe is then delayed to produce update / norm_en / out_valid / done.
// Ports: clk, reset (sync, active high), bus (dnn_seq_if.slave).
module dnn_seq
  import dnn_pkg::*;
#(
  parameter int unsigned BW = 16
) (
  input  logic      clk,
  input  logic      reset,
  dnn_seq_if.slave  bus
);

  seq_state_t      state_q, state_d;
  logic [RA_W-1:0] n_in_q, n_in_d;
  logic [RA_W-1:0] ra_q, ra_d;
  logic [BW-1:0]   n_batch_q, n_batch_d;
  logic [BW-1:0]   sample_q, sample_d;
  logic            busy_q, init_q, exec_q, bias_q;

  logic            last_c;
  logic [1:0]      upd_v, nrm_v, out_v;
  logic [BW-1:0]   idx;

  // Next-state, counter and config-latch logic.
  always_comb begin
    state_d   = state_q;
    n_in_d    = n_in_q;
    n_batch_d = n_batch_q;
    sample_d  = sample_q;
    ra_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.n_batch != '0)) begin
          n_in_d    = bus.n_in;
          n_batch_d = bus.n_batch;
          sample_d  = '0;
          state_d   = INIT;
        end
      end
      INIT: begin
        state_d = (n_in_q != '0) ? EXEC : BIAS;
      end
      EXEC: begin
        if (ra_q == RA_W'(n_in_q - RA_W'(1))) state_d = BIAS;
        else                                  ra_d    = RA_W'(ra_q + RA_W'(1));
      end
      BIAS: begin
        if (sample_q != BW'(n_batch_q - BW'(1))) begin
          sample_d = BW'(sample_q + BW'(1));
          state_d  = INIT;
        end else begin
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        // out_v[1] is the delayed last-sample flag, i.e. the done pulse.
        if (out_v[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and strobes, all registered from next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      n_in_q    <= '0;
      n_batch_q <= '0;
      sample_q  <= '0;
      ra_q      <= '0;
      busy_q    <= 1'b0;
      init_q    <= 1'b0;
      exec_q    <= 1'b0;
      bias_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_in_q    <= n_in_d;
      n_batch_q <= n_batch_d;
      sample_q  <= sample_d;
      ra_q      <= ra_d;
      busy_q    <= (state_d != IDLE);
      init_q    <= (state_d == INIT);
      exec_q    <= (state_d == EXEC);
      bias_q    <= (state_d == BIAS);
    end
  end

  // Tag the bias of the final sample so done lands on its out_valid.
  assign last_c = bias_q && (sample_q == BW'(n_batch_q - BW'(1)));

  // Strobe line {last, bias}, tapped at UPD_LAT, NRM_LAT and OUT_LAT.
  dnn_delay #(.W(2), .DEPTH(UPD_LAT)) u_dly_upd (
    .clk   (clk),
    .reset (reset),
    .d_i   ({last_c, bias_q}),
    .q_o   (upd_v)
  );

  dnn_delay #(.W(2), .DEPTH(NRM_LAT - UPD_LAT)) u_dly_nrm (
    .clk   (clk),
    .reset (reset),
    .d_i   (upd_v),
    .q_o   (nrm_v)
  );

  dnn_delay #(.W(2), .DEPTH(OUT_LAT - NRM_LAT)) u_dly_out (
    .clk   (clk),
    .reset (reset),
    .d_i   (nrm_v),
    .q_o   (out_v)
  );

  // Sample index travelling alongside the strobe line.
  dnn_delay #(.W(BW), .DEPTH(OUT_LAT)) u_dly_idx (
    .clk   (clk),
    .reset (reset),
    .d_i   (sample_q),
    .q_o   (idx)
  );

  assign bus.busy      = busy_q;
  assign bus.init      = init_q;
  assign bus.exec      = exec_q;
  assign bus.bias      = bias_q;
  assign bus.ra        = ra_q;
  assign bus.sample    = sample_q;
  assign bus.update    = upd_v[0];
  assign bus.norm_en   = nrm_v[0];
  assign bus.out_valid = out_v[0];
  assign bus.done      = out_v[1];
  assign bus.out_idx   = idx;

endmodule

// File: doc/dnn_seq.md
# dnn_seq

Control sequencer that sits directly upstream of one `tiny_dnn_core` + `normalize` pair. For each input sample it issues the core's `init`, `exec`, `bias` and `update` strobes, steps the read address `ra`, and enables the `normalize` stage. It also flags the cycle in which the float32 result is valid. A batch of samples is processed back-to-back from a single `start`.

## Interface
- `F_SIZE`, default 1024: core weight-memory depth. The bias lives at `F_SIZE-1`.
- `BW`, default 16: width of the sample counter.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Ignored while `busy`=1 or `n_batch`=0.
- `n_in` in 10: features per sample, legal range 0..F_SIZE-1.
- `n_batch` in BW: number of samples in the batch.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse, coincident with the last `out_valid`.
- `init`, `exec`, `bias`, `update` out 1: strobes to the core.
- `ra` out 10: feature index. It goes to the core and to the input buffer, which has 1-cycle read latency.
- `sample` out BW: index of the sample being fetched. Used as the input-buffer base.
- `norm_en` out 1: drives `normalize.en`.
- `out_valid` out 1: the `normalize.nrm` output is valid this cycle.
- `out_idx` out BW: sample index of the result flagged by `out_valid`.

## Operation
- States are IDLE, INIT, EXEC, BIAS and DRAIN.
- IDLE: on an accepted `start`, latch `n_in` and `n_batch`, clear `sample`, and go to INIT.
- INIT (1 cycle): `init`=1. Go to EXEC if `n_in`≠0, else go to BIAS.
- EXEC (`n_in` cycles): `exec`=1, and `ra` counts 0..`n_in`-1. After the cycle with `ra`=`n_in`-1, go to BIAS.
- BIAS (1 cycle): `bias`=1 and `ra` is don't-care. The core forces the address to F_SIZE-1 and d=1.0 itself.
  - If `sample`≠`n_batch`-1: increment `sample` and go to INIT.
  - Otherwise go to DRAIN.
- Derived strobes come from a 4-stage shift of `bias` plus a parallel shift of `sample`:
  - `update` = `bias` delayed by 2 cycles.
  - `norm_en` = `bias` delayed by 3 cycles.
  - `out_valid` = `bias` delayed by 4 cycles.
  - `out_idx` = `sample` delayed by 4 cycles.
- DRAIN: wait until the last `out_valid`. In that cycle pulse `done`, then go to IDLE.
- `n_in`=0 produces a bias-only pass: result = bias × 1.0.
- Outputs are registered from state/counters. `exec`/`init`/`bias` are mutually exclusive.
- Reset values: all outputs 0, state IDLE, delay lines cleared.
  - Reset mid-batch drops all pending `update`/`norm_en`/`out_valid`.
  - Core accumulator contents are left stale; the next batch's `init` clears them.
- `start` while `busy`=1 is ignored, with no effect on the latched config.
- `start` coincident with `reset`: reset wins.
- `sample` wraps only at `n_batch`-1. `n_batch`=2^BW-1 is legal.

## Timing
- Core alignment, with the accepted `start` at cycle 0:
  - `init` at cycle 1 lands as `init2` at cycle 3.
  - The first `exec` is at cycle 2, `ra` 0.
  - The input buffer must present `d[ra]` during cycle `ra`'s slot +1.
- Per sample, with BIAS at cycle b:
  - `update` at b+2 (same cycle as `bias2`).
  - `addo` is valid at b+3, where `norm_en`=1.
  - `nrm` is valid at b+4, where `out_valid`=1.
- Next sample: INIT at b+1, so its `init2` lands at b+3, after `update` at b+2. There is no hazard.
- Cycles per sample = `n_in`+2. Batch latency from `start` to `done` = `n_batch`·(`n_in`+2)+4.
- `busy` falls the cycle after `done`. A new `start` is accepted in that same cycle (state is IDLE).

## Structure
- Package `dnn_pkg` holds:
  - the state enum `seq_state_t`;
  - `F_SIZE`;
  - latency constants `UPD_LAT`=2, `NRM_LAT`=3, `OUT_LAT`=4.
- Sub-module `dnn_delay`: parameterised-width, parameterised-depth shift register with synchronous reset. Instantiate it for the strobe line and for the `out_idx` line.
- Target size is about 150–220 lines of RTL.

## Test plan
- `n_in`=3, `n_batch`=1, `start` at c0:
  - `init` c1; `exec` c2–c4 with `ra` 0,1,2; `bias` c5; `update` c7; `norm_en` c8.
  - `out_valid`, `done` and `out_idx`=0 at c9; `busy` low at c10.
- `n_in`=2, `n_batch`=3:
  - `out_valid` at c8, c12, c16 with `out_idx` 0,1,2.
  - `done` at c16 only; `init` never overlaps `update`.
- `n_in`=0, `n_batch`=1, with bias weight 0x3f80:
  - no `exec`; `bias` c2; `out_valid` c6.
  - `nrm`=0x3f800000 when attached to the core and `normalize`.
- `start` at c3 of a running batch:
  - ignored; no change in `ra` sequence or `done` timing.
- `n_batch`=0 `start`: ignored, and `busy` stays 0.
- `reset` at c6 of the `n_in`=3 case:
  - all outputs 0 from c7; no `update`/`out_valid` thereafter.
  - A fresh `start` reproduces the first scenario exactly.
